// File: rtl/applications_if.sv
// Grade-evaluation bus: four section grades in, registered classification out.
// APPLICATIONS_TOTAL_OUT_EN adds the registered total to the bus.
interface applications_if #(
    parameter int SUM_W = 10
);
    logic             in_valid;
    logic [7:0]       sect1_grade;
    logic [7:0]       sect2_grade;
    logic [7:0]       sect3_grade;
    logic [7:0]       sect4_grade;
    logic             out_valid;
    logic             failed;
    logic             passed;
    logic             scholarship;
`ifdef APPLICATIONS_TOTAL_OUT_EN
    logic [SUM_W-1:0] total;
`endif

    modport master (
        output in_valid,
        output sect1_grade,
        output sect2_grade,
        output sect3_grade,
        output sect4_grade,
        input  out_valid,
        input  failed,
        input  passed,
`ifdef APPLICATIONS_TOTAL_OUT_EN
        input  total,
`endif
        input  scholarship
    );

    modport slave (
        input  in_valid,
        input  sect1_grade,
        input  sect2_grade,
        input  sect3_grade,
        input  sect4_grade,
        output out_valid,
        output failed,
        output passed,
`ifdef APPLICATIONS_TOTAL_OUT_EN
        output total,
`endif
        output scholarship
    );
endinterface

// File: rtl/applications.sv
// Sums four 8-bit section grades and registers a failed/passed/scholarship verdict.
// Define APPLICATIONS_TOTAL_OUT_EN to also expose the registered total on the bus.
module applications #(
    parameter int PASS_TH  = 100,
    parameter int SCHOL_TH = 200,
    parameter int SUM_W    = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    applications_if.slave bus
);
    localparam logic [SUM_W-1:0] PASS_TH_W  = SUM_W'(PASS_TH);
    localparam logic [SUM_W-1:0] SCHOL_TH_W = SUM_W'(SCHOL_TH);

    logic [SUM_W-1:0] total_c;
    logic             out_valid_d,   out_valid_q;
    logic             failed_d,      failed_q;
    logic             passed_d,      passed_q;
    logic             scholarship_d, scholarship_q;

    assign total_c = SUM_W'(bus.sect1_grade) + SUM_W'(bus.sect2_grade)
                   + SUM_W'(bus.sect3_grade) + SUM_W'(bus.sect4_grade);

    // Flags hold between samples; out_valid only pulses for the cycle after a sample.
    always_comb begin
        out_valid_d   = 1'b0;
        failed_d      = failed_q;
        passed_d      = passed_q;
        scholarship_d = scholarship_q;
        if (bus.in_valid) begin
            out_valid_d   = 1'b1;
            failed_d      = (total_c <  PASS_TH_W);
            passed_d      = (total_c >= PASS_TH_W);
            scholarship_d = (total_c >= SCHOL_TH_W);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            failed_q      <= 1'b0;
            passed_q      <= 1'b0;
            scholarship_q <= 1'b0;
        end else begin
            out_valid_q   <= out_valid_d;
            failed_q      <= failed_d;
            passed_q      <= passed_d;
            scholarship_q <= scholarship_d;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.failed      = failed_q;
    assign bus.passed      = passed_q;
    assign bus.scholarship = scholarship_q;

`ifdef APPLICATIONS_TOTAL_OUT_EN
    logic [SUM_W-1:0] total_d, total_q;

    always_comb begin
        total_d = total_q;
        if (bus.in_valid) begin
            total_d = total_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_q <= '0;
        end else begin
            total_q <= total_d;
        end
    end

    assign bus.total = total_q;
`endif
endmodule

// File: tb/tb_applications.sv
// Directed, table-driven bench for the applications grade classifier.
module tb_applications;
    logic clk;
    logic rst_n;

    applications_if #(.SUM_W(10)) bus ();

    applications #(
        .PASS_TH (100),
        .SCHOL_TH(200),
        .SUM_W   (10)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] g1, g2, g3, g4;
        logic       exp_failed;
        logic       exp_passed;
        logic       exp_schol;
        int         exp_total;
    } vec_t;

    vec_t vecs[8];
    int   compared   = 0;
    int   mismatched = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [7:0] a, input logic [7:0] b,
                                 input logic [7:0] c, input logic [7:0] d);
        @(negedge clk);
        bus.in_valid    = valid;
        bus.sect1_grade = a;
        bus.sect2_grade = b;
        bus.sect3_grade = c;
        bus.sect4_grade = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkFlags(input string tag, input logic ov, input logic f, input logic p,
                              input logic s);
        checkOutput({tag, ".out_valid"},   int'(bus.out_valid),   int'(ov));
        checkOutput({tag, ".failed"},      int'(bus.failed),      int'(f));
        checkOutput({tag, ".passed"},      int'(bus.passed),      int'(p));
        checkOutput({tag, ".scholarship"}, int'(bus.scholarship), int'(s));
    endtask

    initial begin
        vecs[0] = '{8'd0,   8'd10,  8'd30,  8'd20,  1'b1, 1'b0, 1'b0, 60};
        vecs[1] = '{8'd25,  8'd25,  8'd25,  8'd25,  1'b0, 1'b1, 1'b0, 100};
        vecs[2] = '{8'd40,  8'd16,  8'd5,   8'd38,  1'b1, 1'b0, 1'b0, 99};
        vecs[3] = '{8'd62,  8'd81,  8'd37,  8'd19,  1'b0, 1'b1, 1'b0, 199};
        vecs[4] = '{8'd50,  8'd50,  8'd50,  8'd50,  1'b0, 1'b1, 1'b1, 200};
        vecs[5] = '{8'd86,  8'd75,  8'd49,  8'd93,  1'b0, 1'b1, 1'b1, 303};
        vecs[6] = '{8'd255, 8'd255, 8'd255, 8'd255, 1'b0, 1'b1, 1'b1, 1020};
        vecs[7] = '{8'd0,   8'd0,   8'd0,   8'd0,   1'b1, 1'b0, 1'b0, 0};

        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.sect1_grade = 8'd0;
        bus.sect2_grade = 8'd0;
        bus.sect3_grade = 8'd0;
        bus.sect4_grade = 8'd0;

        // Reset state, with a clock edge passing while reset is held.
        @(posedge clk);
        #1;
        checkFlags("reset", 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef APPLICATIONS_TOTAL_OUT_EN
        checkOutput("reset.total", int'(bus.total), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Main table: each vector sampled once, checked one cycle later.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, vecs[i].g1, vecs[i].g2, vecs[i].g3, vecs[i].g4);
            checkFlags($sformatf("vec%0d", i), 1'b1, vecs[i].exp_failed, vecs[i].exp_passed,
                       vecs[i].exp_schol);
`ifdef APPLICATIONS_TOTAL_OUT_EN
            checkOutput($sformatf("vec%0d.total", i), int'(bus.total), vecs[i].exp_total);
`endif
        end

        // Hold: a passed sample followed by an idle cycle with zero grades.
        applyStimulus(1'b1, 8'd73, 8'd18, 8'd20, 8'd0);
        checkFlags("hold.sample", 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        checkFlags("hold.idle1", 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        checkFlags("hold.idle2", 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef APPLICATIONS_TOTAL_OUT_EN
        checkOutput("hold.total", int'(bus.total), 111);
`endif

        // Back-to-back samples: out_valid stays high, each result replaces the last.
        applyStimulus(1'b1, 8'd10, 8'd10, 8'd10, 8'd10);
        checkFlags("b2b.first", 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'd100, 8'd100, 8'd0, 8'd0);
        checkFlags("b2b.second", 1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 8'd50, 8'd50, 8'd0, 8'd0);
        checkFlags("b2b.third", 1'b1, 1'b0, 1'b1, 1'b0);

        // Mid-stream reset between edges clears outputs at once and drops the pending sample.
        @(negedge clk);
        bus.in_valid    = 1'b1;
        bus.sect1_grade = 8'd50;
        bus.sect2_grade = 8'd50;
        bus.sect3_grade = 8'd50;
        bus.sect4_grade = 8'd50;
        #1;
        rst_n = 1'b0;
        #1;
        checkFlags("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef APPLICATIONS_TOTAL_OUT_EN
        checkOutput("rst_mid.total", int'(bus.total), 0);
`endif
        @(posedge clk);
        #1;
        checkFlags("rst_held", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        @(posedge clk);
        #1;
        checkFlags("rst_after", 1'b0, 1'b0, 1'b0, 1'b0);

        // Recovery after reset.
        applyStimulus(1'b1, 8'd40, 8'd16, 8'd5, 8'd39);
        checkFlags("recover", 1'b1, 1'b0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
